// File: rtl/sc_pkg.sv
// Shared constants for the sequence-counter controller: state codes and default sizing.
package sc_pkg;

  localparam int unsigned SC_W     = 4;
  localparam int unsigned MAX_STEP = 7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

endpackage

// File: rtl/sc_counter.sv
// SC register: clear beats hold beats increment; wraps to 0 after MAX_STEP and flags the wrap.
module sc_counter
  import sc_pkg::*;
#(
  parameter int unsigned SC_W     = sc_pkg::SC_W,
  parameter int unsigned MAX_STEP = sc_pkg::MAX_STEP
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            hold,
  output logic [SC_W-1:0] count,
  output logic            wrap
);

  localparam logic [SC_W-1:0] LAST = SC_W'(MAX_STEP);

  assign wrap = ~clr & ~hold & (count == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (!hold) begin
      count <= wrap ? '0 : count + SC_W'(1);
    end
  end

endmodule

// File: rtl/sc_sequencer.sv
// Sequence-counter controller: IDLE/RUN/HALT FSM, one-hot T decode, halt latch and pulses.
// Optional interrupt cycle tracking is enabled by defining SC_SEQ_IRQ_CYCLE_EN.
module sc_sequencer
  import sc_pkg::*;
#(
  parameter int unsigned SC_W     = sc_pkg::SC_W,
  parameter int unsigned T_W      = 2 ** SC_W,
  parameter int unsigned MAX_STEP = sc_pkg::MAX_STEP
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            halt_req,
  input  logic            sc_clr,
  input  logic            stall,
  input  logic            irq,
  input  logic            ien,
  output logic [SC_W-1:0] sc,
  output logic [T_W-1:0]  t,
  output logic            busy,
  output logic            halted,
  output logic            instr_done,
  output logic            overrun,
  output logic            int_cycle
);

  localparam logic [SC_W-1:0] LAST = SC_W'(MAX_STEP);

  logic [1:0] state;
  logic       halt_latch;
  logic       halt_now;
  logic       run;
  logic       wrap;

  assign run      = (state == ST_RUN);
  assign halt_now = halt_latch | halt_req;
  assign busy     = run;
  assign halted   = (state == ST_HALT);

  // Outside RUN the counter is held clear, so entering RUN always starts at T0.
  sc_counter #(
    .SC_W     (SC_W),
    .MAX_STEP (MAX_STEP)
  ) u_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (~run | sc_clr),
    .hold  (stall),
    .count (sc),
    .wrap  (wrap)
  );

  always_comb begin
    t = '0;
    if (run && (sc <= LAST)) begin
      t[sc] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      halt_latch <= 1'b0;
      instr_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      instr_done <= 1'b0;
      overrun    <= 1'b0;
      case (state)
        ST_IDLE: begin
          halt_latch <= 1'b0;
          if (start) state <= ST_RUN;
        end
        ST_RUN: begin
          instr_done <= sc_clr;
          overrun    <= wrap;
          if (sc_clr) begin
            halt_latch <= 1'b0;
            if (halt_now) state <= ST_HALT;
          end else if (halt_req) begin
            halt_latch <= 1'b1;
          end
        end
        ST_HALT: begin
          halt_latch <= 1'b0;
          if (start) state <= ST_RUN;
        end
        default: begin
          state      <= ST_IDLE;
          halt_latch <= 1'b0;
        end
      endcase
    end
  end

`ifdef SC_SEQ_IRQ_CYCLE_EN
  // A pending halt suppresses the interrupt; an active interrupt cycle always ends at its sc_clr.
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      int_cycle <= 1'b0;
    end else if (sc_clr) begin
      int_cycle <= ~int_cycle & irq & ien & ~halt_now;
    end
  end
`else
  logic unused_irq;
  assign unused_irq = irq ^ ien;
  assign int_cycle  = 1'b0;
`endif

endmodule

// File: tb/tb_sc_sequencer.sv
// Bench for sc_sequencer: directed vector table, interrupt/halt sequence, then randomized run against a model.
module tb_sc_sequencer;

  localparam int MAXS = 7;

  logic        clk = 1'b0;
  logic        rst, start, halt_req, sc_clr, stall, irq, ien;
  logic [3:0]  sc;
  logic [15:0] t;
  logic        busy, halted, instr_done, overrun, int_cycle;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  sc_sequencer #(
    .SC_W     (4),
    .T_W      (16),
    .MAX_STEP (MAXS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .halt_req   (halt_req),
    .sc_clr     (sc_clr),
    .stall      (stall),
    .irq        (irq),
    .ien        (ien),
    .sc         (sc),
    .t          (t),
    .busy       (busy),
    .halted     (halted),
    .instr_done (instr_done),
    .overrun    (overrun),
    .int_cycle  (int_cycle)
  );

  typedef struct {
    bit r, s, h, c, st;
    int e_sc;
    int e_t;
    bit e_busy, e_halted, e_done, e_ovr;
  } vec_t;

  vec_t vecs[$];

  // Behavioural reference: plain flags and an integer step count.
  bit m_running, m_halted, m_latch, m_done, m_ovr, m_int;
  int m_sc;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int model_t();
    if (m_running && m_sc <= MAXS) return 1 << m_sc;
    return 0;
  endfunction

  task automatic model_step();
    bit stop;
    if (rst) begin
      m_running = 0; m_halted = 0; m_latch = 0;
      m_done = 0; m_ovr = 0; m_int = 0; m_sc = 0;
    end else if (!m_running) begin
      m_done = 0; m_ovr = 0; m_int = 0; m_sc = 0; m_latch = 0;
      if (start) begin
        m_running = 1;
        m_halted  = 0;
      end
    end else begin
      m_done = sc_clr;
      m_ovr  = 0;
      if (sc_clr) begin
        stop = m_latch || halt_req;
`ifdef SC_SEQ_IRQ_CYCLE_EN
        if (m_int) m_int = 0;
        else       m_int = irq && ien && !stop;
`endif
        m_sc    = 0;
        m_latch = 0;
        if (stop) begin
          m_running = 0;
          m_halted  = 1;
          m_int     = 0;
        end
      end else begin
        if (halt_req) m_latch = 1;
        if (!stall) begin
          if (m_sc == MAXS) begin
            m_sc  = 0;
            m_ovr = 1;
          end else begin
            m_sc = m_sc + 1;
          end
        end
      end
    end
  endtask

  task automatic drive(input bit r, s, h, c, st, iq, ie);
    rst = r; start = s; halt_req = h; sc_clr = c; stall = st; irq = iq; ien = ie;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".sc"},         int'(sc),         m_sc);
    chk({tag, ".t"},          int'(t),          model_t());
    chk({tag, ".busy"},       int'(busy),       int'(m_running));
    chk({tag, ".halted"},     int'(halted),     int'(m_halted));
    chk({tag, ".instr_done"}, int'(instr_done), int'(m_done));
    chk({tag, ".overrun"},    int'(overrun),    int'(m_ovr));
    chk({tag, ".int_cycle"},  int'(int_cycle),  int'(m_int));
  endtask

  task automatic add(input bit r, s, h, c, st, input int esc, et,
                     input bit b, hl, d, o);
    vec_t v;
    v = '{r, s, h, c, st, esc, et, b, hl, d, o};
    vecs.push_back(v);
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0);
    // rst start halt clr stall | sc t busy halted done ovr
    add(1,0,0,0,0, 0,'h0000, 0,0,0,0);
    add(0,1,0,0,0, 0,'h0001, 1,0,0,0);
    add(0,0,0,0,0, 1,'h0002, 1,0,0,0);
    add(0,0,0,0,0, 2,'h0004, 1,0,0,0);
    add(0,0,0,0,1, 2,'h0004, 1,0,0,0);
    add(0,0,0,0,1, 2,'h0004, 1,0,0,0);
    add(0,0,0,0,1, 2,'h0004, 1,0,0,0);
    add(0,0,0,0,0, 3,'h0008, 1,0,0,0);
    add(0,0,0,1,1, 0,'h0001, 1,0,1,0);
    add(0,0,0,0,0, 1,'h0002, 1,0,0,0);
    add(0,0,1,0,0, 2,'h0004, 1,0,0,0);
    add(0,0,0,0,0, 3,'h0008, 1,0,0,0);
    add(0,0,0,0,0, 4,'h0010, 1,0,0,0);
    add(0,0,0,1,0, 0,'h0000, 0,1,1,0);
    add(0,0,0,1,0, 0,'h0000, 0,1,0,0);
    add(0,1,0,0,0, 0,'h0001, 1,0,0,0);
    add(0,0,0,0,0, 1,'h0002, 1,0,0,0);
    add(0,0,0,0,0, 2,'h0004, 1,0,0,0);
    add(0,0,0,0,0, 3,'h0008, 1,0,0,0);
    add(0,0,0,0,0, 4,'h0010, 1,0,0,0);
    add(0,0,0,0,0, 5,'h0020, 1,0,0,0);
    add(0,0,0,0,0, 6,'h0040, 1,0,0,0);
    add(0,0,0,0,0, 7,'h0080, 1,0,0,0);
    add(0,0,0,0,0, 0,'h0001, 1,0,0,1);
    add(0,0,0,0,0, 1,'h0002, 1,0,0,0);
    add(0,0,0,0,0, 2,'h0004, 1,0,0,0);
    add(0,0,0,0,0, 3,'h0008, 1,0,0,0);
    add(0,0,0,0,0, 4,'h0010, 1,0,0,0);
    add(0,0,0,0,0, 5,'h0020, 1,0,0,0);
    add(0,0,0,0,0, 6,'h0040, 1,0,0,0);
    add(1,0,0,0,0, 0,'h0000, 0,0,0,0);
    add(0,1,1,0,0, 0,'h0001, 1,0,0,0);
    add(0,0,0,1,0, 0,'h0001, 1,0,1,0);
    add(0,0,1,1,0, 0,'h0000, 0,1,1,0);
    add(0,1,0,0,0, 0,'h0001, 1,0,0,0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].r, vecs[i].s, vecs[i].h, vecs[i].c, vecs[i].st, 0, 0);
      cycle();
      chk($sformatf("vec%0d.sc", i),         int'(sc),         vecs[i].e_sc);
      chk($sformatf("vec%0d.t", i),          int'(t),          vecs[i].e_t);
      chk($sformatf("vec%0d.busy", i),       int'(busy),       int'(vecs[i].e_busy));
      chk($sformatf("vec%0d.halted", i),     int'(halted),     int'(vecs[i].e_halted));
      chk($sformatf("vec%0d.instr_done", i), int'(instr_done), int'(vecs[i].e_done));
      chk($sformatf("vec%0d.overrun", i),    int'(overrun),    int'(vecs[i].e_ovr));
      chk($sformatf("vec%0d.int_cycle", i),  int'(int_cycle),  0);
    end

    // Interrupt entry/exit, then halt taking precedence over a pending interrupt.
    drive(1, 0, 0, 0, 0, 0, 0); cycle(); check_model("irq_rst");
    drive(0, 1, 0, 0, 0, 0, 0); cycle(); check_model("irq_start");
    drive(0, 0, 0, 0, 0, 1, 1); cycle(); check_model("irq_step");
    drive(0, 0, 0, 1, 0, 1, 1); cycle(); check_model("irq_take");
    drive(0, 0, 0, 0, 0, 1, 1); cycle(); check_model("irq_body");
    drive(0, 0, 0, 0, 1, 0, 0); cycle(); check_model("irq_stall");
    drive(0, 0, 0, 1, 0, 1, 1); cycle(); check_model("irq_end");
    drive(0, 0, 1, 0, 0, 1, 1); cycle(); check_model("irq_hreq");
    drive(0, 0, 0, 1, 0, 1, 1); cycle(); check_model("irq_halt");
    drive(0, 1, 0, 0, 0, 1, 1); cycle(); check_model("irq_resume");

    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 63) == 0,
            $urandom_range(0, 7) == 0,
            $urandom_range(0, 15) == 0,
            $urandom_range(0, 6) == 0,
            $urandom_range(0, 3) == 0,
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
      cycle();
      check_model($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sc_sequencer.md
Name: sc_sequencer

Overview:
- Sequence-counter controller for the basic-computer control unit.
- Owns the 4-bit sequence counter SC and produces the one-hot timing vector T0..T15 that drives the control-word logic.
- Handles start/halt, stall (hold), end-of-instruction clear, runaway-counter recovery and, optionally, the interrupt cycle.
- Sits between the control-unit decode logic, which supplies sc_clr and stall, and every T-gated register transfer.

Parameters:
- SC_W, 4, sequence counter width.
- T_W, 16, timing vector width; must equal 2**SC_W.
- MAX_STEP, 7, last legal step index; counting past it is an overrun.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin or resume sequencing; acted on in IDLE and HALT only.
- halt_req  input  1  request to halt at the next instruction boundary; sampled in RUN only.
- sc_clr  input  1  end of instruction; clear SC.
- stall  input  1  hold SC at its current value this cycle.
- irq  input  1  interrupt request (level).
- ien  input  1  interrupt enable flag (IEN).
- sc  output  SC_W  current sequence count.
- t  output  T_W  one-hot timing vector.
- busy  output  1  high while in RUN.
- halted  output  1  high while in HALT.
- instr_done  output  1  one-cycle pulse after each sc_clr.
- overrun  output  1  one-cycle pulse after a MAX_STEP wrap.
- int_cycle  output  1  high while executing the interrupt cycle.

Behaviour:
- FSM states: IDLE, RUN, HALT.
- Reset values: state=IDLE, sc=0, t=0, busy=0, halted=0, instr_done=0, overrun=0, int_cycle=0; halt latch cleared.
- t is combinational from sc and state:
  - In RUN: t = 1<<sc when sc<=MAX_STEP, otherwise all zero.
  - In IDLE and HALT: t = 0.
- IDLE:
  - start=1: next state RUN, sc=0, so T0 is high in the first RUN cycle.
  - halt_req is ignored.
- RUN, evaluated each cycle in this priority order:
  1. sc_clr=1: sc<=0 and instr_done=1 next cycle. If the halt latch is set, next state is HALT and the latch clears.
  2. stall=1: sc holds.
  3. sc==MAX_STEP: sc<=0 and overrun=1 next cycle. instr_done stays 0 and the state stays RUN.
  4. Otherwise: sc<=sc+1.
- sc_clr and stall asserted together: sc_clr wins.
- Halt latch:
  - Set by halt_req in any RUN cycle; sticky until the next sc_clr.
  - halt_req in the same cycle as sc_clr halts at that boundary.
- HALT:
  - sc=0, halted=1, busy=0.
  - start=1: next state RUN with sc=0.
  - sc_clr, stall and halt_req are ignored.
- Latency: control input to new sc/t is 1 cycle. instr_done and overrun are registered pulses, 1 cycle wide.
- Reset in any state, including mid-instruction: all outputs return to reset values on the next edge; no partial step completes.
- MAX_STEP=T_W-1: the wrap from 15 to 0 still reports overrun.

Optional Feature:
- Macro: SC_SEQ_IRQ_CYCLE_EN.
- Defined:
  - Taking the interrupt: at an sc_clr with irq=1, ien=1 and the halt latch clear, int_cycle<=1 for the next instruction's steps.
  - Ending the interrupt cycle: int_cycle clears at the following sc_clr.
  - Precedence: halt beats interrupt. irq is not re-sampled while int_cycle=1.
- Undefined: int_cycle is tied to 0; irq and ien stay on the port list but are unused.

Decomposition:
- Shared package sc_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_HALT=2'd2;
  - defaults SC_W and MAX_STEP.
- One natural sub-module, sc_counter:
  - the SC register with clear > hold > increment priority and a wrap flag;
  - the FSM and t decode stay in sc_sequencer.

Test Plan:
- Reset, then start=1 for 1 cycle, no other inputs → sc runs 0..7, then overrun=1 the cycle after the 7→0 wrap; T-vector bit 3 is 16'h0008 when sc=3.
- RUN, sc_clr=1 at sc=4 → sc=0 and instr_done=1 next cycle, t=16'h0001.
- stall=1 for 3 cycles at sc=2 → sc stays 2 and t=16'h0004 throughout; sc_clr+stall together → sc=0.
- halt_req=1 at sc=1, sc_clr at sc=5 → HALT next cycle: halted=1, sc=0, t=0; then start=1 → RUN, t=16'h0001.
- With SC_SEQ_IRQ_CYCLE_EN: irq=1, ien=1 at sc_clr → int_cycle=1 until the next sc_clr; with halt_req also latched → HALT and int_cycle stays 0.
- rst=1 while sc=6 in RUN → next edge: state IDLE, sc=0, t=0, busy=0, all pulses 0.
